// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst types, response codes and the slave's channel state encodings.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi_slave_addr_gen.sv
// Per-beat address logic for one AXI channel: next beat address, memory word index,
// range check and detection of burst/size settings the slave cannot serve.
module axi_slave_addr_gen
    import axi_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int data_width = 64,
    parameter int mem_depth  = 256
) (
    input  logic [addr_width-1:0]        addr,
    input  logic [2:0]                   size,
    input  logic [1:0]                   burst,
    output logic [addr_width-1:0]        next_addr,
    output logic [$clog2(mem_depth)-1:0] word_idx,
    output logic                         in_range,
    output logic                         cfg_err
);

    localparam int BYTE_SHIFT = $clog2(data_width / 8);
    localparam int IDX_W      = $clog2(mem_depth);
    // One extra bit so a memory spanning the whole address space still compares correctly.
    localparam logic [addr_width:0] MEM_BYTES = (addr_width + 1)'(mem_depth * (data_width / 8));

    always_comb begin
        next_addr = addr;
        if (burst == BURST_INCR) begin
            next_addr = addr + (addr_width'(1) << size);
        end
    end

    assign word_idx = addr[BYTE_SHIFT +: IDX_W];
    assign in_range = ({1'b0, addr} < MEM_BYTES);
    assign cfg_err  = ((burst != BURST_FIXED) && (burst != BURST_INCR)) ||
                      (int'(size) > BYTE_SHIFT);

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave with a word-addressed scratchpad: independent single-outstanding write and
// read channels, byte-strobed writes, OKAY/SLVERR responses.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int data_width = 64,
    parameter int id_width   = 8,
    parameter int mem_depth  = 256
) (
    input  logic                    AClk,
    input  logic                    ARst,
    input  logic [id_width-1:0]     AWID,
    input  logic [addr_width-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic [1:0]              AWLOCK,
    input  logic [1:0]              AWCACHE,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [7:0]              WID,
    input  logic [data_width-1:0]   WDATA,
    input  logic [data_width/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [id_width-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [id_width-1:0]     ARID,
    input  logic [addr_width-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic [1:0]              ARLOCK,
    input  logic [1:0]              ARCACHE,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [id_width-1:0]     RID,
    output logic [data_width-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int STRB_W = data_width / 8;
    localparam int IDX_W  = $clog2(mem_depth);

    logic [data_width-1:0] mem [mem_depth];
    logic                  started;

    w_state_t              w_state, w_next;
    logic [id_width-1:0]   w_id;
    logic [addr_width-1:0] w_addr, w_gen_next;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  w_err, w_in_range, w_cfg_err, w_last_beat, w_beat_err;
    logic [IDX_W-1:0]      w_idx;
    logic                  aw_hs, w_hs;

    r_state_t              r_state, r_next;
    logic [id_width-1:0]   r_id;
    logic [addr_width-1:0] r_next_addr, r_gen_addr, r_gen_next;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size, r_gen_size;
    logic [1:0]            r_burst, r_gen_burst;
    logic                  r_in_range, r_cfg_err, r_last_beat, r_beat_err, r_load;
    logic [IDX_W-1:0]      r_idx;
    logic                  ar_hs, r_hs;

    logic                  unused_inputs;
    assign unused_inputs = ^{AWLOCK, AWCACHE, AWPROT, WID, ARLOCK, ARCACHE, ARPROT};

    // Keeps both address channels closed until the first clock edge after reset is released.
    always_ff @(posedge AClk or posedge ARst) begin
        if (ARst) started <= 1'b0;
        else      started <= 1'b1;
    end

    assign aw_hs       = AWVALID && AWREADY;
    assign w_hs        = WVALID && WREADY;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_err  = w_cfg_err || !w_in_range || (WLAST != w_last_beat);

    assign AWREADY = started && (w_state == W_IDLE);
    assign WREADY  = (w_state == W_DATA);
    assign BVALID  = (w_state == W_RESP);
    assign BID     = w_id;
    assign BRESP   = w_err ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge AClk or posedge ARst) begin
        if (ARst) w_state <= W_IDLE;
        else      w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge AClk or posedge ARst) begin
        if (ARst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= AWID;
            w_addr  <= AWADDR;
            w_len   <= AWLEN;
            w_size  <= AWSIZE;
            w_burst <= AWBURST;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= w_gen_next;
            if (w_beat_err) w_err <= 1'b1;
        end
    end

    // Storage is deliberately unreset; only in-range beats touch it.
    always_ff @(posedge AClk) begin
        if (w_hs && w_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    axi_slave_addr_gen #(
        .addr_width(addr_width),
        .data_width(data_width),
        .mem_depth (mem_depth)
    ) u_w_gen (
        .addr     (w_addr),
        .size     (w_size),
        .burst    (w_burst),
        .next_addr(w_gen_next),
        .word_idx (w_idx),
        .in_range (w_in_range),
        .cfg_err  (w_cfg_err)
    );

    assign ar_hs       = ARVALID && ARREADY;
    assign r_hs        = RVALID && RREADY;
    assign r_last_beat = (r_cnt == r_len);
    assign r_load      = ar_hs || (r_hs && !r_last_beat);
    assign r_beat_err  = r_cfg_err || !r_in_range;

    assign ARREADY = started && (r_state == R_IDLE);
    assign RVALID  = (r_state == R_DATA);
    assign RLAST   = (r_state == R_DATA) && r_last_beat;
    assign RID     = r_id;

    // The read generator looks at the beat about to be loaded: the AR request while idle,
    // otherwise the address queued up behind the beat currently on the bus.
    assign r_gen_addr  = (r_state == R_IDLE) ? ARADDR  : r_next_addr;
    assign r_gen_size  = (r_state == R_IDLE) ? ARSIZE  : r_size;
    assign r_gen_burst = (r_state == R_IDLE) ? ARBURST : r_burst;

    always_ff @(posedge AClk or posedge ARst) begin
        if (ARst) r_state <= R_IDLE;
        else      r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge AClk or posedge ARst) begin
        if (ARst) begin
            r_id        <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_cnt       <= '0;
            r_next_addr <= '0;
            RDATA       <= '0;
            RRESP       <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                r_id    <= ARID;
                r_len   <= ARLEN;
                r_size  <= ARSIZE;
                r_burst <= ARBURST;
                r_cnt   <= '0;
            end else if (r_hs) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_load) begin
                r_next_addr <= r_gen_next;
                if (r_beat_err) begin
                    RDATA <= '0;
                    RRESP <= RESP_SLVERR;
                end else begin
                    RDATA <= mem[r_idx];
                    RRESP <= RESP_OKAY;
                end
            end
        end
    end

    axi_slave_addr_gen #(
        .addr_width(addr_width),
        .data_width(data_width),
        .mem_depth (mem_depth)
    ) u_r_gen (
        .addr     (r_gen_addr),
        .size     (r_gen_size),
        .burst    (r_gen_burst),
        .next_addr(r_gen_next),
        .word_idx (r_idx),
        .in_range (r_in_range),
        .cfg_err  (r_cfg_err)
    );

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized bench for axi_slave_mem: a byte-level memory model fills expectation queues
// and an independent monitor checks every B and R handshake against them.
module tb_axi_slave_mem;
    import axi_pkg::*;

    localparam int MEM_BYTES = 2048;

    logic        AClk = 1'b0;
    logic        ARst = 1'b1;
    logic [7:0]  AWID, WID, BID, ARID, RID, AWLEN, ARLEN;
    logic [31:0] AWADDR, ARADDR;
    logic [2:0]  AWSIZE, AWPROT, ARSIZE, ARPROT;
    logic [1:0]  AWBURST, AWLOCK, AWCACHE, ARBURST, ARLOCK, ARCACHE, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;

    always #5 AClk = ~AClk;

    axi_slave_mem dut (
        .AClk(AClk), .ARst(ARst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    logic [63:0] ref_mem   [256];
    logic [63:0] wdata_buf [256];
    logic [7:0]  wstrb_buf [256];
    int          tests = 0;
    int          fails = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int beat,
                                              input logic [2:0] size, input logic [1:0] burst);
        if (burst == BURST_FIXED) return start;
        return start + 32'(beat) * (32'd1 << size);
    endfunction

    function automatic bit cfg_bad(input logic [2:0] size, input logic [1:0] burst);
        return (burst != BURST_FIXED && burst != BURST_INCR) || (size > 3'd3);
    endfunction

    // sel: 0=AWREADY 1=WREADY 2=ARREADY 3=B handshake; returns #1 after the handshake edge.
    task automatic wait_hs(input int sel, input string name);
        bit hs;
        int cyc;
        hs  = 1'b0;
        cyc = 0;
        while (!hs) begin
            @(negedge AClk);
            case (sel)
                0:       hs = AWREADY;
                1:       hs = WREADY;
                2:       hs = ARREADY;
                default: hs = BVALID && BREADY;
            endcase
            @(posedge AClk);
            #1;
            cyc++;
            if (!hs && cyc > 100) begin
                tests++;
                fails++;
                $display("[TB] FAIL %s: no handshake after 100 cycles, wanted one", name);
                return;
            end
        end
    endtask

    task automatic apply_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input int bad_last, input int bready_wait);
        logic [31:0] a;
        bit          err;
        b_exp_t      e;
        err = cfg_bad(size, burst);
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, i, size, burst);
            if (i == bad_last) err = 1'b1;
            if (a >= MEM_BYTES) begin
                err = 1'b1;
            end else begin
                for (int b = 0; b < 8; b++)
                    if (wstrb_buf[i][b]) ref_mem[a[10:3]][b*8 +: 8] = wdata_buf[i][b*8 +: 8];
            end
        end
        e.id   = id;
        e.resp = err ? RESP_SLVERR : RESP_OKAY;
        exp_b.push_back(e);

        AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1;
        wait_hs(0, "aw_handshake");
        AWVALID = 1'b0;
        check_output("aw_ready_busy", {63'd0, AWREADY}, 64'd0);
        check_output("w_ready_open", {63'd0, WREADY}, 64'd1);
        for (int i = 0; i <= len; i++) begin
            WDATA  = wdata_buf[i];
            WSTRB  = wstrb_buf[i];
            WLAST  = (i == len) ^ (i == bad_last);
            WVALID = 1'b1;
            wait_hs(1, "w_handshake");
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        check_output("b_valid_after_last", {63'd0, BVALID}, 64'd1);
        repeat (bready_wait) begin
            @(posedge AClk);
            #1;
        end
        BREADY = 1'b1;
        wait_hs(3, "b_handshake");
        BREADY = 1'b0;
    endtask

    // rmode: 0 = RREADY always high, 1 = random, 2 = repeating 1,0,0,1.
    task automatic apply_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                              input logic [2:0] size, input logic [1:0] burst, input int rmode);
        logic [31:0] a;
        bit          err;
        r_exp_t      e;
        int          got, cyc;
        for (int i = 0; i <= len; i++) begin
            a      = beat_addr(addr, i, size, burst);
            err    = cfg_bad(size, burst) || (a >= MEM_BYTES);
            e.id   = id;
            e.data = err ? 64'd0 : ref_mem[a[10:3]];
            e.resp = err ? RESP_SLVERR : RESP_OKAY;
            e.last = (i == len);
            exp_r.push_back(e);
        end

        ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        wait_hs(2, "ar_handshake");
        ARVALID = 1'b0;
        check_output("r_valid_next", {63'd0, RVALID}, 64'd1);
        check_output("ar_ready_busy", {63'd0, ARREADY}, 64'd0);
        got = 0;
        cyc = 0;
        while (got <= len && cyc < 2000) begin
            case (rmode)
                0:       RREADY = 1'b1;
                1:       RREADY = 1'($urandom_range(0, 1));
                default: RREADY = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            @(negedge AClk);
            if (RVALID && RREADY) got++;
            @(posedge AClk);
            #1;
            cyc++;
        end
        RREADY = 1'b0;
        check_output("r_beat_count", 64'(got), 64'(len + 1));
        check_output("ar_ready_idle", {63'd0, ARREADY}, 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_awready"}, {63'd0, AWREADY}, 64'd0);
        check_output({tag, "_wready"},  {63'd0, WREADY},  64'd0);
        check_output({tag, "_bvalid"},  {63'd0, BVALID},  64'd0);
        check_output({tag, "_bid"},     {56'd0, BID},     64'd0);
        check_output({tag, "_bresp"},   {62'd0, BRESP},   64'd0);
        check_output({tag, "_arready"}, {63'd0, ARREADY}, 64'd0);
        check_output({tag, "_rvalid"},  {63'd0, RVALID},  64'd0);
        check_output({tag, "_rid"},     {56'd0, RID},     64'd0);
        check_output({tag, "_rdata"},   RDATA,            64'd0);
        check_output({tag, "_rresp"},   {62'd0, RRESP},   64'd0);
        check_output({tag, "_rlast"},   {63'd0, RLAST},   64'd0);
    endtask

    // Monitor: pops expectations at each handshake and checks outputs hold during stalls.
    logic   b_held = 1'b0;
    logic   r_held = 1'b0;
    b_exp_t b_hold, b_cur;
    r_exp_t r_hold, r_cur;

    always @(negedge AClk) begin
        if (ARst) begin
            b_held = 1'b0;
            r_held = 1'b0;
        end else begin
            if (BVALID) begin
                if (b_held) begin
                    check_output("b_stable_id", {56'd0, BID}, {56'd0, b_hold.id});
                    check_output("b_stable_resp", {62'd0, BRESP}, {62'd0, b_hold.resp});
                end
                if (BREADY) begin
                    b_held = 1'b0;
                    if (exp_b.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL b_unexpected: got BID 0x%0h, wanted no response", BID);
                    end else begin
                        b_cur = exp_b.pop_front();
                        check_output("b_id", {56'd0, BID}, {56'd0, b_cur.id});
                        check_output("b_resp", {62'd0, BRESP}, {62'd0, b_cur.resp});
                    end
                end else begin
                    b_held = 1'b1;
                    b_hold = {BID, BRESP};
                end
            end
            if (RVALID) begin
                if (r_held) begin
                    check_output("r_stable_data", RDATA, r_hold.data);
                    check_output("r_stable_resp", {62'd0, RRESP}, {62'd0, r_hold.resp});
                    check_output("r_stable_last", {63'd0, RLAST}, {63'd0, r_hold.last});
                end
                if (RREADY) begin
                    r_held = 1'b0;
                    if (exp_r.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL r_unexpected: got RDATA 0x%0h, wanted no beat", RDATA);
                    end else begin
                        r_cur = exp_r.pop_front();
                        check_output("r_id", {56'd0, RID}, {56'd0, r_cur.id});
                        check_output("r_data", RDATA, r_cur.data);
                        check_output("r_resp", {62'd0, RRESP}, {62'd0, r_cur.resp});
                        check_output("r_last", {63'd0, RLAST}, {63'd0, r_cur.last});
                    end
                end else begin
                    r_held = 1'b1;
                    r_hold = {RID, RDATA, RRESP, RLAST};
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          len, bad;
        logic [2:0]  sz;
        logic [1:0]  bt;

        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWLOCK = 0; AWCACHE = 0;
        AWPROT = 0; AWVALID = 0; WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0;
        BREADY = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARLOCK = 0;
        ARCACHE = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;

        repeat (3) @(posedge AClk);
        #1;
        check_all_zero("rst");
        ARst = 1'b0;
        @(negedge AClk);
        check_output("aw_ready_before_edge", {63'd0, AWREADY}, 64'd0);
        @(posedge AClk);
        #1;
        check_output("aw_ready_after_rst", {63'd0, AWREADY}, 64'd1);
        check_output("ar_ready_after_rst", {63'd0, ARREADY}, 64'd1);

        // Give the whole memory known contents.
        for (int i = 0; i < 256; i++) begin
            wdata_buf[i] = {$urandom, $urandom};
            wstrb_buf[i] = 8'hFF;
        end
        apply_write(8'h01, 32'h0, 255, 3'd3, BURST_INCR, -1, 0);
        apply_read(8'h02, 32'h0, 255, 3'd3, BURST_INCR, 1);

        for (int i = 0; i < 4; i++) begin
            wdata_buf[i] = 64'hA0 + 64'(i);
            wstrb_buf[i] = 8'hFF;
        end
        apply_write(8'd3, 32'h10, 3, 3'd3, BURST_INCR, -1, 2);
        apply_read(8'd3, 32'h10, 3, 3'd3, BURST_INCR, 0);

        wdata_buf[0] = 64'h1111_2222_3333_4444;
        wstrb_buf[0] = 8'hFF;
        apply_write(8'd4, 32'h100, 0, 3'd3, BURST_INCR, -1, 0);
        wdata_buf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wstrb_buf[0] = 8'h0F;
        apply_write(8'd4, 32'h100, 0, 3'd3, BURST_INCR, -1, 1);
        apply_read(8'd4, 32'h100, 0, 3'd3, BURST_INCR, 0);

        for (int i = 0; i < 3; i++) begin
            wdata_buf[i] = 64'(i + 1);
            wstrb_buf[i] = 8'hFF;
        end
        apply_write(8'd5, 32'h20, 2, 3'd3, BURST_FIXED, -1, 0);
        apply_read(8'd5, 32'h20, 0, 3'd3, BURST_INCR, 0);

        wdata_buf[0] = {$urandom, $urandom};
        wdata_buf[1] = {$urandom, $urandom};
        wstrb_buf[0] = 8'hFF;
        wstrb_buf[1] = 8'hFF;
        apply_write(8'd6, 32'h7F8, 1, 3'd3, BURST_INCR, -1, 0);
        apply_read(8'd6, 32'h7F8, 1, 3'd3, BURST_INCR, 0);

        apply_read(8'd7, 32'h40, 3, 3'd3, BURST_INCR, 2);
        apply_read(8'd8, 32'h40, 3, 3'd3, BURST_WRAP, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 270)) * 32'd8;
            else                           a = 32'($urandom_range(0, 2200));
            len = int'($urandom_range(0, 7));
            sz  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 2)) : 3'd3;
            if ($urandom_range(0, 1) == 1) begin
                bt  = 2'($urandom_range(0, 1));
                bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
                for (int i = 0; i <= len; i++) begin
                    wdata_buf[i] = {$urandom, $urandom};
                    wstrb_buf[i] = 8'($urandom);
                end
                apply_write(8'($urandom), a, len, sz, bt, bad, int'($urandom_range(0, 3)));
            end else begin
                bt = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) sz = 3'($urandom_range(4, 7));
                apply_read(8'($urandom), a, len, sz, bt, int'($urandom_range(0, 2)));
            end
        end

        // Reset in the middle of a write burst: two beats land, the third never does.
        for (int i = 0; i < 8; i++) wdata_buf[i] = {$urandom, $urandom};
        AWID = 8'd9; AWADDR = 32'h200; AWLEN = 8'd7; AWSIZE = 3'd3; AWBURST = BURST_INCR;
        AWVALID = 1'b1;
        wait_hs(0, "aw_rst_handshake");
        AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            WDATA = wdata_buf[i]; WSTRB = 8'hFF; WLAST = 1'b0; WVALID = 1'b1;
            wait_hs(1, "w_rst_handshake");
            ref_mem[64 + i] = wdata_buf[i];
        end
        WDATA = wdata_buf[2];
        @(negedge AClk);
        ARst = 1'b1;
        #1;
        check_all_zero("midrst");
        WVALID = 1'b0;
        @(posedge AClk);
        #1;
        ARst = 1'b0;
        @(posedge AClk);
        #1;
        check_output("aw_ready_after_midrst", {63'd0, AWREADY}, 64'd1);
        check_output("ar_ready_after_midrst", {63'd0, ARREADY}, 64'd1);
        apply_read(8'd10, 32'h200, 7, 3'd3, BURST_INCR, 0);

        repeat (2) @(posedge AClk);
        check_output("b_queue_drained", 64'(exp_b.size()), 64'd0);
        check_output("r_queue_drained", 64'(exp_r.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI4 slave endpoint with an internal word-addressed memory, the responder counterpart of the AXI master control FSMs. It accepts one write burst and one read burst at a time on independent channels, stores write data under byte strobes, and returns read data and write responses. It serves as the target model behind the master in integration benches and as a small on-chip scratchpad.

## Interface
- addr_width, 32: AW/AR address width.
- data_width, 64: W/R data width; strobe width is data_width/8.
- id_width, 8: AWID/BID/ARID/RID width.
- mem_depth, 256: memory depth in data_width words; power of two.
---
- AClk  in  1  single clock; all logic on its rising edge.
- ARst  in  1  reset, asynchronous, active-high.
- AWID  in  id_width; AWADDR  in  addr_width; AWLEN  in  8; AWSIZE  in  3; AWBURST  in  2.
- AWLOCK  in  2; AWCACHE  in  2; AWPROT  in  3: accepted and ignored.
- AWVALID  in  1; AWREADY  out  1.
- WID  in  8 (ignored); WDATA  in  data_width; WSTRB  in  data_width/8; WLAST  in  1; WVALID  in  1; WREADY  out  1.
- BID  out  id_width; BRESP  out  2; BVALID  out  1; BREADY  in  1.
- ARID  in  id_width; ARADDR  in  addr_width; ARLEN  in  8; ARSIZE  in  3; ARBURST  in  2; ARLOCK  in  2 / ARCACHE  in  2 / ARPROT  in  3 (ignored); ARVALID  in  1; ARREADY  out  1.
- RID  out  id_width; RDATA  out  data_width; RRESP  out  2; RLAST  out  1; RVALID  out  1; RREADY  in  1.

## Operation
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE. Read FSM: R_IDLE -> R_DATA -> R_IDLE. Independent; one outstanding transaction each.
- W_IDLE: AWREADY=1; AW handshake latches ID, address, LEN, SIZE, BURST; beat counter=0; error flag cleared.
- W_DATA: WREADY=1; each W handshake writes WDATA bytes with WSTRB=1 to word (addr >> log2(data_width/8)) when in range; counter++ and address advances. Burst ends on beat AWLEN+1 irrespective of WLAST.
- W_RESP: BVALID=1, BID=latched ID, BRESP=OKAY(00) or SLVERR(10); leaves on BREADY.
- R_IDLE: ARREADY=1; AR handshake latches fields, loads RDATA for beat 0.
- R_DATA: RVALID=1, RID=latched ID, RLAST=1 when counter==ARLEN; on RREADY advance and load next word; after last beat -> R_IDLE.
- Address generation: FIXED(00) holds address; INCR(01) adds 2^SIZE bytes per beat, width addr_width, wrap at 2^addr_width. WRAP(10) and reserved(11) unsupported.
- SLVERR per burst (B) when: unsupported BURST, SIZE > log2(data_width/8), any beat address >= mem_depth*data_width/8 (that beat not written), or WLAST value mismatching last-beat position.
- SLVERR per beat (R): unsupported BURST, oversize SIZE, or out-of-range beat; that beat RDATA=0. Otherwise RRESP=OKAY.
- Memory contents are not reset.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=0, ARREADY=0, RVALID=0, RID=0, RDATA=0, RRESP=0, RLAST=0. AWREADY/ARREADY go 1 on first AClk edge after ARst falls.
- AW handshake cycle N -> WREADY=1 from N+1. AWREADY=0 from N+1 until the cycle after B handshake.
- Last W beat cycle M -> BVALID=1 from M+1; held with stable BID/BRESP until BREADY.
- AR handshake cycle N -> RVALID=1 with beat 0 at N+1; back-to-back beats, one per cycle under RREADY=1. RDATA/RRESP/RLAST stable while RVALID&!RREADY.
- ARREADY=0 from N+1 until the cycle after last R handshake.
- Same word written and read-loaded in one cycle: read gets old data.
- ARst mid-burst: both FSMs to IDLE, outputs to reset values immediately; beats already written stay committed.

## Structure
- Shared package axi_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR, write/read state encodings.
- Sub-module axi_slave_addr_gen: next-address and range-check logic, instantiated once per channel.

## Test plan
- Reset then AW (ID=3, ADDR=0x10, LEN=3, SIZE=3, INCR) + 4 beats 0xA0..0xA3, WSTRB=0xFF -> BVALID one cycle after 4th beat, BID=3, BRESP=00; AR same params -> RDATA 0xA0..0xA3, RLAST on 4th, RRESP=00.
- WSTRB=0x0F write 0xFFFF_FFFF_FFFF_FFFF over 0x1111_2222_3333_4444 -> read returns 0x1111_2222_FFFF_FFFF.
- FIXED burst LEN=2 to 0x20, data 1,2,3 -> read 0x20 returns 3.
- INCR LEN=1 starting at last word 0x7F8 -> BRESP=10, word 0x7F8 written; read same -> beat0 RRESP=00, beat1 RRESP=10 RDATA=0.
- RREADY toggled 1,0,0,1 during LEN=3 read -> data held stable, 4 beats in order, no drop/duplicate; BURST=WRAP -> all beats SLVERR.
- ARst pulsed during beat 2 of LEN=7 write -> all outputs 0 at once; AWREADY=1 one cycle after release; beats 0-1 readable.
